// File: rtl/mem_arbiter_sram.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_sram
//  Description : Multi-port arbiter and width adapter for an external
//                asynchronous SRAM. One requester is granted at a time. Each
//                WORD_W-bit word moves as WORD_W/RAM_W RAM beats, least
//                significant slice first. Every transfer ends with a
//                one-cycle req_ack pulse to the granted port.
//  Options     : `define MEM_ARB_RR_EN selects round-robin arbitration.
//                Without it, arbitration is fixed priority (port 0 highest).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_sram #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 18,
    parameter int WORD_W    = 32,
    parameter int RAM_W     = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req_en,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*WORD_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          req_ack,
    output logic [WORD_W-1:0]             rdata,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [RAM_W-1:0]              ram_wdata,
    input  logic [RAM_W-1:0]              ram_rdata,
    output logic                          ram_oe,
    output logic                          ram_wre_n,
    output logic                          busy
);

    localparam int c_BEATS = WORD_W / RAM_W;
    localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BEAT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // A word that does not split into whole RAM beats cannot be serialised.
    generate
        if ((WORD_W % RAM_W) != 0 || WORD_W < RAM_W) begin : g_bad_width
            $error("mem_arbiter_sram: WORD_W must be an integer multiple of RAM_W");
        end
        if (NUM_PORTS < 1 || NUM_PORTS > 8) begin : g_bad_ports
            $error("mem_arbiter_sram: NUM_PORTS must be in the range 1..8");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_beat;
    logic [c_IDX_W-1:0]  r_grant;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic [WORD_W-1:0]   r_shadow;
    logic [WORD_W-1:0]   r_rdata;

    logic [c_IDX_W-1:0]  w_win;
    logic                w_strobe;

`ifdef MEM_ARB_RR_EN
    logic [c_IDX_W-1:0]  r_last;
    logic [c_IDX_W-1:0]  w_idx;

    // Round-robin: scan from last_grant+1 upwards; descending loop lets the nearest port win.
    always_comb begin
        w_win = '0;
        w_idx = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_idx = c_IDX_W'((int'(r_last) + k) % NUM_PORTS);
            if (req_en[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    // Remember the most recent winner so the next search rotates past it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last <= '0;
        end else if (r_state == c_IDLE && |req_en) begin
            r_last <= w_win;
        end
    end
`else
    // Fixed priority: descending loop leaves the lowest active index as the winner.
    always_comb begin
        w_win = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_en[i]) begin
                w_win = c_IDX_W'(i);
            end
        end
    end
`endif

    // Transfer sequencer: latch the winner in IDLE, walk the beats, acknowledge in DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_beat   <= '0;
            r_grant  <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_shadow <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|req_en) begin
                        r_grant <= w_win;
                        r_we    <= req_we[w_win];
                        r_addr  <= req_addr[w_win*ADDR_W +: ADDR_W];
                        r_wdata <= req_wdata[w_win*WORD_W +: WORD_W];
                        r_beat  <= '0;
                        r_state <= c_BEAT;
                    end
                end
                c_BEAT: begin
                    // The asynchronous RAM has settled by the end of the beat cycle.
                    if (!r_we) begin
                        r_shadow[r_beat*RAM_W +: RAM_W] <= ram_rdata;
                    end
                    if (r_beat == c_LAST_BEAT) begin
                        r_state <= c_DONE;
                    end else begin
                        r_beat <= r_beat + c_CNT_W'(1);
                    end
                end
                c_DONE: begin
                    if (!r_we) begin
                        r_rdata <= r_shadow;
                    end
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // RAM bus, acknowledge and read-data decode from the registered transfer state.
    always_comb begin
        w_strobe  = (r_state == c_BEAT) && r_we;
        ram_addr  = r_addr + ADDR_W'(r_beat);
        ram_wdata = r_wdata[r_beat*RAM_W +: RAM_W];
        ram_oe    = w_strobe;
        ram_wre_n = ~w_strobe;
        busy      = (r_state != c_IDLE);
        // The shadow word is already complete in DONE, so a read presents it one cycle early.
        rdata     = (r_state == c_DONE && !r_we) ? r_shadow : r_rdata;
        req_ack   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_ack[i] = (r_state == c_DONE) && (r_grant == c_IDX_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_sram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter_sram
//  Description : Self-checking bench for mem_arbiter_sram. Instance A uses the
//                default geometry, instance B a 3-port 64/16 geometry. Each
//                has a behavioural asynchronous SRAM. Expected acks are queued
//                when requests are driven and are compared when req_ack pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_sram;

    localparam int AW  = 18;
    localparam int WW  = 32;
    localparam int NP  = 2;
    localparam int AWB = 10;
    localparam int WWB = 64;
    localparam int NPB = 3;

    typedef struct {
        int          port;
        bit          we;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          perturb;
    } vec_t;

    typedef struct {
        int          port;
        logic [63:0] rd;
    } exp_t;

    typedef struct {
        logic [17:0] addr;
        logic [15:0] data;
    } beat_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // ---------------- instance A ----------------
    logic [NP-1:0]    a_en, a_we, a_ack;
    logic [NP*AW-1:0] a_addr;
    logic [NP*WW-1:0] a_wdata;
    logic [WW-1:0]    a_rdata;
    logic [AW-1:0]    a_ram_addr;
    logic [15:0]      a_ram_wdata, a_ram_rdata;
    logic             a_oe, a_wre_n, a_busy;
    logic [15:0]      mem_a [0:(1<<AW)-1];

    mem_arbiter_sram #(.NUM_PORTS(NP), .ADDR_W(AW), .WORD_W(WW), .RAM_W(16)) u_dut_a (
        .clock(clock), .reset(reset),
        .req_en(a_en), .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
        .req_ack(a_ack), .rdata(a_rdata),
        .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
        .ram_oe(a_oe), .ram_wre_n(a_wre_n), .busy(a_busy)
    );

    assign a_ram_rdata = mem_a[a_ram_addr];
    always @(posedge clock) if (a_wre_n === 1'b0) mem_a[a_ram_addr] <= a_ram_wdata;

    // ---------------- instance B ----------------
    logic [NPB-1:0]     b_en, b_we, b_ack;
    logic [NPB*AWB-1:0] b_addr;
    logic [NPB*WWB-1:0] b_wdata;
    logic [WWB-1:0]     b_rdata;
    logic [AWB-1:0]     b_ram_addr;
    logic [15:0]        b_ram_wdata, b_ram_rdata;
    logic               b_oe, b_wre_n, b_busy;
    logic [15:0]        mem_b [0:(1<<AWB)-1];

    mem_arbiter_sram #(.NUM_PORTS(NPB), .ADDR_W(AWB), .WORD_W(WWB), .RAM_W(16)) u_dut_b (
        .clock(clock), .reset(reset),
        .req_en(b_en), .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
        .req_ack(b_ack), .rdata(b_rdata),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
        .ram_oe(b_oe), .ram_wre_n(b_wre_n), .busy(b_busy)
    );

    assign b_ram_rdata = mem_b[b_ram_addr];
    always @(posedge clock) if (b_wre_n === 1'b0) mem_b[b_ram_addr] <= b_ram_wdata;

    // ---------------- checking infrastructure ----------------
    int    checks = 0;
    int    errors = 0;
    exp_t  sb_a[$];
    exp_t  sb_b[$];
    beat_t log_a[$];
    exp_t  mon_a_e, mon_b_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] pat(input int a);
        pat = 16'((a * 40503) ^ 23130);
    endfunction

    function automatic logic [63:0] pat_b(input int a);
        pat_b = {pat((a + 3) % 1024), pat((a + 2) % 1024), pat((a + 1) % 1024), pat(a % 1024)};
    endfunction

    // Monitor A: log write strobes and retire scoreboard entries on each ack.
    always @(negedge clock) begin
        if (a_wre_n === 1'b0) log_a.push_back('{addr: a_ram_addr, data: a_ram_wdata});
        if (a_wre_n === 1'b0 || a_oe === 1'b1) check("a_oe_vs_wre_n", a_oe, !a_wre_n);
        if (a_ack != '0) begin
            if (sb_a.size() == 0) begin
                check("a_unexpected_ack", a_ack, 0);
            end else begin
                mon_a_e = sb_a.pop_front();
                check("a_ack_port", a_ack, 64'(1) << mon_a_e.port);
                check("a_rdata", a_rdata, mon_a_e.rd);
            end
        end
    end

    // Monitor B: retire scoreboard entries on each ack.
    always @(negedge clock) begin
        if (b_ack != '0) begin
            if (sb_b.size() == 0) begin
                check("b_unexpected_ack", b_ack, 0);
            end else begin
                mon_b_e = sb_b.pop_front();
                check("b_ack_port", b_ack, 64'(1) << mon_b_e.port);
                check("b_rdata", b_rdata, mon_b_e.rd);
            end
        end
    end

    // One single-port transfer on instance A with latency and strobe checks.
    task automatic run_a(input vec_t v);
        int n;
        sb_a.push_back('{port: v.port, rd: 64'(v.exp_rd)});
        log_a.delete();
        a_en = '0;
        a_we = '0;
        a_en[v.port] = 1'b1;
        a_we[v.port] = v.we;
        a_addr[v.port*AW +: AW]  = v.addr;
        a_wdata[v.port*WW +: WW] = v.wdata;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (n == 1 && v.perturb) begin
                a_en    = '0;
                a_we    = ~a_we;
                a_addr  = '1;
                a_wdata = '0;
            end
            if (a_ack != '0) break;
        end
        check("a_ack_latency", n, 3);
        a_en = '0;
        if (v.we) begin
            check("a_strobe_count", log_a.size(), 2);
            for (int k = 0; k < 2 && k < log_a.size(); k++) begin
                check("a_strobe_addr", log_a[k].addr, AW'(v.addr + 18'(k)));
                check("a_strobe_data", log_a[k].data, v.wdata[k*16 +: 16]);
            end
        end else begin
            check("a_read_no_strobe", log_a.size(), 0);
        end
        tick();
        check("a_idle_after", a_busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];
    int   n, got, p;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_a[i] = pat(i);
        for (int i = 0; i < (1 << AWB); i++) mem_b[i] = pat(i);
        mem_a[18'h00010] = 16'h1234;
        mem_a[18'h00011] = 16'hABCD;

        vecs[0] = '{0, 1'b0, 18'h00010, 32'h0,        32'hABCD1234, 1'b0};
        vecs[1] = '{1, 1'b1, 18'h3FFFF, 32'hDEADBEEF, 32'hABCD1234, 1'b0};
        vecs[2] = '{1, 1'b0, 18'h00100, 32'h0,        {pat(32'h101), pat(32'h100)}, 1'b0};
        vecs[3] = '{0, 1'b1, 18'h00200, 32'h0F1E2D3C, {pat(32'h101), pat(32'h100)}, 1'b0};
        vecs[4] = '{0, 1'b0, 18'h3FFFF, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[5] = '{1, 1'b0, 18'h00200, 32'h0,        32'h0F1E2D3C, 1'b0};
        vecs[6] = '{0, 1'b1, 18'h00300, 32'h11112222, 32'h0F1E2D3C, 1'b1};
        vecs[7] = '{0, 1'b0, 18'h00300, 32'h0,        32'h11112222, 1'b0};

        reset = 1'b1;
        a_en = '0; a_we = '0; a_addr = '0; a_wdata = '0;
        b_en = '0; b_we = '0; b_addr = '0; b_wdata = '0;
        repeat (3) tick();

        check("rst_a_ack",       a_ack, 0);
        check("rst_a_rdata",     a_rdata, 0);
        check("rst_a_ram_addr",  a_ram_addr, 0);
        check("rst_a_ram_wdata", a_ram_wdata, 0);
        check("rst_a_oe",        a_oe, 0);
        check("rst_a_wre_n",     a_wre_n, 1);
        check("rst_a_busy",      a_busy, 0);
        check("rst_b_rdata",     b_rdata, 0);
        check("rst_b_busy",      b_busy, 0);
        check("rst_b_wre_n",     b_wre_n, 1);

        reset = 1'b0;
        tick();

        // B: all three ports hold their requests for six transfers.
        b_we = '0;
        b_addr = {10'h3FC, 10'h200, 10'h100};
        for (int k = 0; k < 6; k++) begin
`ifdef MEM_ARB_RR_EN
            p = (k + 1) % 3;
`else
            p = 0;
`endif
            sb_b.push_back('{port: p, rd: pat_b(p == 0 ? 32'h100 : (p == 1 ? 32'h200 : 32'h3FC))});
        end
        b_en = 3'b111;
        n = 0; got = 0;
        while (got < 6 && n < 80) begin
            tick();
            n++;
            if (b_ack != '0) begin
                check("b_hold_ack_cycle", n, 5 + 6 * got);
                got++;
                if (got == 6) b_en = '0;
            end
        end
        check("b_hold_count", got, 6);
        tick();
        check("b_idle_after_hold", b_busy, 0);

        // B: four-beat read wrapping past the top address.
        sb_b.push_back('{port: 2, rd: pat_b(32'h3FE)});
        b_addr[2*AWB +: AWB] = 10'h3FE;
        b_en = 3'b100;
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (b_ack != '0) break;
        end
        check("b_wrap_latency", n, 5);
        b_en = '0;
        tick();

        // A: table of single transfers.
        for (int i = 0; i < 8; i++) run_a(vecs[i]);

        // A: simultaneous requests from both ports, held until acked.
`ifdef MEM_ARB_RR_EN
        sb_a.push_back('{port: 1, rd: {pat(32'h101), pat(32'h100)}});
        sb_a.push_back('{port: 0, rd: 64'h00000000ABCD1234});
`else
        sb_a.push_back('{port: 0, rd: 64'h00000000ABCD1234});
        sb_a.push_back('{port: 1, rd: {pat(32'h101), pat(32'h100)}});
`endif
        a_we = '0;
        a_addr = {18'h00100, 18'h00010};
        a_en = 2'b11;
        n = 0; got = 0;
        while (got < 2 && n < 30) begin
            tick();
            n++;
            if (a_ack != '0) begin
                got++;
                if (got == 1) check("a_sim_first_cycle", n, 3);
                else          check("a_sim_second_cycle", n, 7);
                a_en = a_en & ~a_ack;
            end
        end
        check("a_sim_count", got, 2);
        a_en = '0;
        tick();

        // A: reset during beat 1 of a write, request held through reset.
        log_a.delete();
        a_en = 2'b01;
        a_we = 2'b01;
        a_addr[0 +: AW]  = 18'h00400;
        a_wdata[0 +: WW] = 32'hCAFEF00D;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("a_rst_mid_wre_n", a_wre_n, 1);
        check("a_rst_mid_busy",  a_busy, 0);
        check("a_rst_mid_ack",   a_ack, 0);
        check("a_rst_mid_rdata", a_rdata, 0);
        check("a_rst_mid_beats", log_a.size(), 2);
        reset = 1'b0;
        sb_a.push_back('{port: 0, rd: 64'h0});
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (a_ack != '0) break;
        end
        check("a_rst_restart_latency", n, 3);
        a_en = '0;
        check("a_rst_restart_beats", log_a.size(), 4);
        if (log_a.size() == 4) begin
            check("a_rst_beat2_addr", log_a[2].addr, 18'h00400);
            check("a_rst_beat2_data", log_a[2].data, 16'hF00D);
            check("a_rst_beat3_addr", log_a[3].addr, 18'h00401);
            check("a_rst_beat3_data", log_a[3].data, 16'hCAFE);
        end
        tick();
        run_a('{0, 1'b0, 18'h00400, 32'h0, 32'hCAFEF00D, 1'b0});

        repeat (2) tick();
        check("a_scoreboard_empty", sb_a.size(), 0);
        check("b_scoreboard_empty", sb_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
